// File: rtl/biquad_sequencer.sv
// Direct-form-I biquad that time-shares one multiplier over five MAC steps.
// The coefficient table sits outside the block and answers sel_cte combinationally on cte.
module biquad_sequencer #(
  parameter int cant_bits = 25,
  parameter int frac_bits = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_tick,
  input  logic [cant_bits-1:0] x_in,
  input  logic [cant_bits-1:0] cte,
  output logic [3:0]           sel_cte,
  output logic [cant_bits-1:0] y_out,
  output logic                 y_valid,
  output logic                 busy,
  output logic                 overrun,
  output logic                 sat_flag
);
  localparam int PROD_W = 2 * cant_bits;
  localparam int ACC_W  = 2 * cant_bits + 3;
  localparam logic signed [ACC_W-1:0] RND  = ACC_W'(1) << (frac_bits - 1);
  localparam logic signed [ACC_W-1:0] YMAX = (ACC_W'(1) << (cant_bits - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] YMIN = -(ACC_W'(1) << (cant_bits - 1));

  typedef enum logic [1:0] {IDLE, MAC, SCALE, OUT} state_t;

  state_t                    r_state, w_next;
  logic [2:0]                r_step, w_step_next;
  logic [3:0]                r_sel, w_sel_next;
  logic                      w_busy, w_start;
  logic [cant_bits-1:0]      r_x0, r_x1, r_x2, r_y1, r_y2, r_y_out;
  logic                      r_y_valid, r_ovr, r_sat;
  logic signed [ACC_W-1:0]   r_acc;
  logic [cant_bits-1:0]      w_op;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]   w_rnd, w_shr;
  logic [cant_bits-1:0]      w_sat;
  logic                      w_clamp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (sample_tick) w_next = MAC;
      MAC:     if (r_step == 3'd4) w_next = SCALE;
      SCALE:   w_next = OUT;
      OUT:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // sel_cte is computed one step ahead so the registered select lines up with its product
  always_comb begin
    w_busy      = (r_state != IDLE);
    w_start     = (r_state == IDLE) && sample_tick;
    w_step_next = 3'd0;
    if (r_state == MAC) w_step_next = r_step + 3'd1;
    w_sel_next  = 4'b0000;
    if (w_next == MAC) begin
      case (w_step_next)
        3'd0:    w_sel_next = 4'b0101;
        3'd1:    w_sel_next = 4'b0110;
        3'd2:    w_sel_next = 4'b0111;
        3'd3:    w_sel_next = 4'b0001;
        3'd4:    w_sel_next = 4'b0010;
        default: w_sel_next = 4'b0000;
      endcase
    end
  end

  always_comb begin
    case (r_step)
      3'd0:    w_op = r_x0;
      3'd1:    w_op = r_x1;
      3'd2:    w_op = r_x2;
      3'd3:    w_op = r_y1;
      3'd4:    w_op = r_y2;
      default: w_op = '0;
    endcase
  end

  assign w_prod = $signed(w_op) * $signed(cte);

  // Round half up, then clamp to the output range
  assign w_rnd = r_acc + RND;
  assign w_shr = w_rnd >>> frac_bits;
  always_comb begin
    w_clamp = 1'b0;
    w_sat   = w_shr[cant_bits-1:0];
    if (w_shr > YMAX) begin
      w_clamp = 1'b1;
      w_sat   = {1'b0, {(cant_bits-1){1'b1}}};
    end else if (w_shr < YMIN) begin
      w_clamp = 1'b1;
      w_sat   = {1'b1, {(cant_bits-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step    <= '0;
      r_sel     <= '0;
      r_acc     <= '0;
      r_x0      <= '0;
      r_x1      <= '0;
      r_x2      <= '0;
      r_y1      <= '0;
      r_y2      <= '0;
      r_y_out   <= '0;
      r_y_valid <= 1'b0;
      r_ovr     <= 1'b0;
      r_sat     <= 1'b0;
    end else begin
      r_step    <= (w_next == MAC) ? w_step_next : 3'd0;
      r_sel     <= w_sel_next;
      r_y_valid <= 1'b0;
      if (sample_tick && w_busy) r_ovr <= 1'b1;
      if (w_start) begin
        r_x0  <= x_in;
        r_acc <= '0;
      end
      if (r_state == MAC)
        r_acc <= r_acc + {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
      // Result lands on the edge into OUT so y_valid is visible while in OUT
      if (r_state == SCALE) begin
        r_y_out   <= w_sat;
        r_y_valid <= 1'b1;
        r_x2      <= r_x1;
        r_x1      <= r_x0;
        r_y2      <= r_y1;
        r_y1      <= w_sat;
        if (w_clamp) r_sat <= 1'b1;
      end
    end
  end

  assign sel_cte  = r_sel;
  assign y_out    = r_y_out;
  assign y_valid  = r_y_valid;
  assign busy     = w_busy;
  assign overrun  = r_ovr;
  assign sat_flag = r_sat;
endmodule

// File: tb/tb_biquad_sequencer.sv
// Scoreboard bench: stimulus pushes hand-computed outputs, a negedge monitor pops on y_valid.
module tb_biquad_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_tick = 1'b0;
  logic [24:0] x_in = '0;
  logic [24:0] cte;
  logic [3:0]  sel_cte;
  logic [24:0] y_out;
  logic        y_valid, busy, overrun, sat_flag;

  int          checks = 0;
  int          failures = 0;
  int          n_valid = 0;
  logic [24:0] exp_q[$];
  logic [24:0] mon_exp;

  always #5 clk = ~clk;

  biquad_sequencer #(.cant_bits(25), .frac_bits(14)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .x_in(x_in), .cte(cte),
    .sel_cte(sel_cte), .y_out(y_out), .y_valid(y_valid), .busy(busy),
    .overrun(overrun), .sat_flag(sat_flag)
  );

  always_comb begin
    case (sel_cte)
      4'b0101, 4'b0111: cte = 25'h0003FDF;
      4'b0110:          cte = 25'h1FF8042;
      4'b0001:          cte = 25'h0007FBE;
      4'b0010:          cte = 25'h1FFC042;
      default:          cte = 25'h0000000;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (y_valid !== 1'b0) begin
      n_valid++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL y_valid_unexpected actual=%h expected=none", y_out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (y_out !== mon_exp) begin
          failures++;
          $display("FAIL y_out actual=%h expected=%h", y_out, mon_exp);
        end
      end
    end
  end

  // Returns at the negedge of the first busy cycle
  task automatic tick(input logic [24:0] x);
    @(negedge clk);
    sample_tick = 1'b1;
    x_in = x;
    @(negedge clk);
    sample_tick = 1'b0;
    x_in = '0;
  endtask

  task automatic issue(input logic [24:0] x, input logic [24:0] e);
    exp_q.push_back(e);
    tick(x);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_timeout", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_sel"}, sel_cte, 4'b0000);
    chk({tag, "_y_out"}, y_out, 0);
    chk({tag, "_y_valid"}, y_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_sat"}, sat_flag, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] seq_sel [7];
    int nv;
    seq_sel = '{4'b0101, 4'b0110, 4'b0111, 4'b0001, 4'b0010, 4'b0000, 4'b0000};

    // Reset with clock running, then silence until a tick
    repeat (3) @(negedge clk);
    check_reset_outputs("init");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_valid_after_reset", n_valid, 0);

    // Impulse response
    issue(25'h0004000, 25'h0003FDF);
    wait_drain();
    repeat (3) @(negedge clk);
    chk("y_out_hold", y_out, 25'h0003FDF);
    issue(25'h0000000, 25'h1FFFFBE);
    wait_drain();

    // Sequencing: x=0 with history x1=0,x2=0x4000,y1=-66,y2=0x3FDF gives -66
    exp_q.push_back(25'h1FFFFBE);
    tick(25'h0000000);
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("seq_sel_%0d", k), sel_cte, seq_sel[k]);
      chk($sformatf("seq_busy_%0d", k), busy, 1);
      chk($sformatf("seq_valid_%0d", k), y_valid, (k == 6));
      @(negedge clk);
    end
    chk("seq_idle_busy", busy, 0);
    chk("seq_idle_sel", sel_cte, 4'b0000);
    wait_drain();

    // Overrun: second tick at t+3 dropped, tick at t+8 accepted
    do_reset();
    nv = n_valid;
    exp_q.push_back(25'h0003FDF);
    tick(25'h0004000);
    @(negedge clk);
    @(negedge clk);
    sample_tick = 1'b1;
    x_in = 25'h0001234;
    @(negedge clk);
    sample_tick = 1'b0;
    x_in = '0;
    chk("overrun_set", overrun, 1);
    repeat (3) @(negedge clk);
    chk("ovr_valid_t7", y_valid, 1);
    issue(25'h0000000, 25'h1FFFFBE);
    wait_drain();
    chk("ovr_valid_count", n_valid - nv, 2);
    chk("overrun_sticky", overrun, 1);

    // Saturation
    do_reset();
    issue(25'h0FFFFFF, 25'h0FF7BFF);
    wait_drain();
    chk("sat_clear", sat_flag, 0);
    issue(25'h1000000, 25'h1000000);
    wait_drain();
    chk("sat_set", sat_flag, 1);
    repeat (3) @(negedge clk);
    chk("sat_sticky", sat_flag, 1);

    // Reset mid-MAC aborts; fresh impulse afterwards
    do_reset();
    nv = n_valid;
    tick(25'h0004000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_no_valid", n_valid - nv, 0);
    issue(25'h0004000, 25'h0003FDF);
    wait_drain();

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
